// File: rtl/mem_serial_host_pkg.sv
// Shared definitions for the memory serial command host.
// Default field widths, FSM state encoding and beat-count helpers.
// Pure declarations; no logic, no latency, no flow control.
package mem_serial_host_pkg;

   localparam int ADDR_BITS_DEF   = 6;
   localparam int DATA_BITS_DEF   = 8;
   localparam int SERIAL_BITS_DEF = 2;
   localparam int TIMEOUT_DEF     = 255;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_WAIT,
      ST_RESP
   } state_e;

   // Number of serial beats needed to carry a field of 'bits' bits.
   function automatic int beats_for(input int bits, input int sb);
      return (bits + sb - 1) / sb;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mem_serial_host_ser_shift_reg.sv
// Parameterised shift register: parallel load, LSB-first shift-out, MSB-side shift-in.
// Latency: one cycle per operation; q_nxt exposes the value q takes at the next edge.
// No flow control: load has priority over shift-out, which has priority over shift-in.
module ser_shift_reg #(
   parameter int W  = 8,
   parameter int SB = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [W-1:0]  load_dat,
   input  logic          shift_out,
   input  logic          shift_in,
   input  logic [SB-1:0] sin,
   output logic [W-1:0]  q,
   output logic [W-1:0]  q_nxt
);

   logic [W-1:0] word_q;
   logic [W-1:0] word_d;

   // Next word: load a new frame, drop the low beat, or push a beat in at the top.
   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = load_dat;
      end else if (shift_out) begin
         word_d = word_q >> SB;
      end else if (shift_in) begin
         word_d = (word_q >> SB) | (W'(sin) << (W - SB));
      end
   end

   // Word register, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q     = word_q;
   assign q_nxt = word_d;

endmodule

// File: rtl/mem_serial_host.sv
// Host initiator: turns parallel read/write requests into serial command frames and reassembles serial read replies.
// Latency: CMD beat one cycle after accept; write frame 1+AB+DB cycles; rsp one cycle after the last reply beat.
// Backpressure: req_ready is high only while idle; reply beats may arrive with gaps, a silent reply times out.
module mem_serial_host
   import mem_serial_host_pkg::*;
#(
   parameter int ADDR_BITS   = ADDR_BITS_DEF,
   parameter int DATA_BITS   = DATA_BITS_DEF,
   parameter int SERIAL_BITS = SERIAL_BITS_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_BITS-1:0]   req_addr,
   input  logic [DATA_BITS-1:0]   req_wdata,
   output logic                   ser_valid,
   output logic [SERIAL_BITS-1:0] ser_out,
   input  logic                   ser_in_vld,
   input  logic [SERIAL_BITS-1:0] ser_in,
   output logic                   rsp_valid,
   output logic [DATA_BITS-1:0]   rsp_data,
   output logic                   rsp_tmo
);

   localparam int AB  = beats_for(ADDR_BITS, SERIAL_BITS);
   localparam int DB  = beats_for(DATA_BITS, SERIAL_BITS);
   localparam int AW  = AB * SERIAL_BITS;
   localparam int DW  = DB * SERIAL_BITS;
   localparam int TW  = AW + DW;
   localparam int BCW = $clog2(max2(AB, DB) + 1);
   localparam int TCW = $clog2(TIMEOUT + 1);

   state_e                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [BCW-1:0]        bcnt_q, bcnt_d;
   logic [TCW-1:0]        tmo_q, tmo_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_tmo_q, rsp_tmo_d;
   logic [DATA_BITS-1:0]  rsp_data_q, rsp_data_d;

   logic                  tx_load;
   logic                  tx_shift;
   logic [TW-1:0]         tx_load_dat;
   logic [TW-1:0]         tx_q;
   logic [TW-1:0]         tx_q_nxt;
   logic                  rx_shift;
   logic [DW-1:0]         rx_q;
   logic [DW-1:0]         rx_q_nxt;
   logic [AW-1:0]         addr_pad;
   logic [DW-1:0]         data_pad;
   logic                  unused_bits;

   // Tx frame image: data above address, both zero-padded to whole beats so the low beat goes first.
   always_comb begin
      addr_pad                 = '0;
      data_pad                 = '0;
      addr_pad[ADDR_BITS-1:0]  = req_addr;
      data_pad[DATA_BITS-1:0]  = req_wdata;
      tx_load_dat              = {data_pad, addr_pad};
   end

   ser_shift_reg #(
      .W  (TW),
      .SB (SERIAL_BITS)
   ) u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_dat  (tx_load_dat),
      .shift_out (tx_shift),
      .shift_in  (1'b0),
      .sin       ('0),
      .q         (tx_q),
      .q_nxt     (tx_q_nxt)
   );

   ser_shift_reg #(
      .W  (DW),
      .SB (SERIAL_BITS)
   ) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (1'b0),
      .load_dat  ('0),
      .shift_out (1'b0),
      .shift_in  (rx_shift),
      .sin       (ser_in),
      .q         (rx_q),
      .q_nxt     (rx_q_nxt)
   );

   // Only the low tx beat and the rx next-word are consumed.
   assign unused_bits = ^{tx_q[TW-1:SERIAL_BITS], tx_q_nxt, rx_q};

   // Next-state, beat/timeout counters and response generation.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      bcnt_d      = bcnt_q;
      tmo_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_tmo_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               tx_load = 1'b1;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            bcnt_d  = '0;
            state_d = ST_ADDR;
         end
         ST_ADDR: begin
            tx_shift = 1'b1;
            if (bcnt_q == BCW'(AB - 1)) begin
               bcnt_d  = '0;
               state_d = wr_q ? ST_DATA : ST_WAIT;
            end else begin
               bcnt_d = bcnt_q + BCW'(1);
            end
         end
         ST_DATA: begin
            tx_shift = 1'b1;
            if (bcnt_q == BCW'(DB - 1)) begin
               bcnt_d  = '0;
               state_d = ST_IDLE;
            end else begin
               bcnt_d = bcnt_q + BCW'(1);
            end
         end
         ST_WAIT: begin
            // Timeout response is launched one cycle early so it is visible
            // exactly when the counter reads TIMEOUT; leave on that cycle.
            tmo_d = tmo_q + TCW'(1);
            if (tmo_q == TCW'(TIMEOUT)) begin
               tmo_d   = '0;
               state_d = ST_IDLE;
            end else if (ser_in_vld) begin
               rx_shift = 1'b1;
               tmo_d    = '0;
               if (DB == 1) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rx_q_nxt[DATA_BITS-1:0];
                  state_d     = ST_IDLE;
               end else begin
                  bcnt_d  = BCW'(1);
                  state_d = ST_RESP;
               end
            end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_tmo_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (ser_in_vld) begin
               rx_shift = 1'b1;
               if (bcnt_q == BCW'(DB - 1)) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rx_q_nxt[DATA_BITS-1:0];
                  bcnt_d      = '0;
                  state_d     = ST_IDLE;
               end else begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and response registers; reset drops any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         bcnt_q      <= '0;
         tmo_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tmo_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         bcnt_q      <= bcnt_d;
         tmo_q       <= tmo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tmo_q   <= rsp_tmo_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Serial and handshake outputs decoded from the current state only.
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      ser_valid = 1'b0;
      ser_out   = '0;
      case (state_q)
         ST_CMD: begin
            ser_valid = 1'b1;
            ser_out   = SERIAL_BITS'(wr_q);
         end
         ST_ADDR, ST_DATA: begin
            ser_valid = 1'b1;
            ser_out   = tx_q[SERIAL_BITS-1:0];
         end
         default: begin
            ser_valid = 1'b0;
         end
      endcase
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tmo   = rsp_tmo_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mem_serial_host.sv
// Self-checking bench for mem_serial_host with default widths.
// Beat and response scoreboards are filled as requests are issued and drained by a monitor.
// Timing-sensitive properties are checked inline by each scenario task.
module tb_mem_serial_host;

   localparam int AB  = 3;
   localparam int DB  = 4;
   localparam int TMO = 255;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       req_valid  = 1'b0;
   logic       req_write  = 1'b0;
   logic [5:0] req_addr   = '0;
   logic [7:0] req_wdata  = '0;
   logic       ser_in_vld = 1'b0;
   logic [1:0] ser_in     = '0;
   logic       req_ready;
   logic       ser_valid;
   logic [1:0] ser_out;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_tmo;

   int errors   = 0;
   int checks   = 0;
   int beat_cnt = 0;

   logic [1:0] beat_q[$];
   logic [8:0] rsp_q[$];   // {tmo, data}

   always #5 clk = ~clk;

   mem_serial_host #(
      .ADDR_BITS   (6),
      .DATA_BITS   (8),
      .SERIAL_BITS (2),
      .TIMEOUT     (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .ser_valid  (ser_valid),
      .ser_out    (ser_out),
      .ser_in_vld (ser_in_vld),
      .ser_in     (ser_in),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_tmo    (rsp_tmo)
   );

   // Scoreboard monitor: every serial beat and every response is popped and compared.
   always @(negedge clk) begin
      logic [1:0] eb;
      logic [8:0] er;
      if (rst_n) begin
         if (ser_valid) begin
            beat_cnt++;
            checks++;
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: got ser_out=%b, expected no beat", ser_out);
            end else begin
               eb = beat_q.pop_front();
               if (ser_out !== eb) begin
                  errors++;
                  $display("FAIL beat_value: got %b, expected %b", ser_out, eb);
               end
            end
         end
         if (rsp_valid) begin
            checks++;
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got data=%h tmo=%b, expected no response", rsp_data, rsp_tmo);
            end else begin
               er = rsp_q.pop_front();
               if ({rsp_tmo, rsp_data} !== er) begin
                  errors++;
                  $display("FAIL rsp_value: got tmo=%b data=%h, expected tmo=%b data=%h",
                           rsp_tmo, rsp_data, er[8], er[7:0]);
               end
            end
         end
      end
   end

   task automatic push_frame(input logic w, input logic [5:0] a, input logic [7:0] d);
      beat_q.push_back({1'b0, w});
      for (int i = 0; i < AB; i++) beat_q.push_back(a[2*i +: 2]);
      if (w) begin
         for (int i = 0; i < DB; i++) beat_q.push_back(d[2*i +: 2]);
      end
   endtask

   // Offer a request from a negedge; returns at the negedge after acceptance (CMD cycle).
   task automatic send_req(input logic w, input logic [5:0] a, input logic [7:0] d);
      logic ok;
      ok        = 1'b0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) ok = 1'b1;
         @(negedge clk);
         if (ok) break;
      end
      req_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL req_accept: got no accept in 50 cycles, expected req_ready");
      end
   endtask

   // Drive the reply word LSB beat first, with 'gap' idle cycles between beats.
   task automatic drive_reply(input logic [7:0] word, input int gap);
      for (int i = 0; i < DB; i++) begin
         ser_in_vld = 1'b1;
         ser_in     = word[2*i +: 2];
         @(negedge clk);
         ser_in_vld = 1'b0;
         ser_in     = 2'b11;
         if (i < DB - 1) repeat (gap) @(negedge clk);
      end
      ser_in = 2'b00;
   endtask

   task automatic test_reset();
      int b0;
      #12;
      checks += 6;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b, expected 1", req_ready); end
      if (ser_valid !== 1'b0) begin errors++; $display("FAIL rst_ser_valid: got %b, expected 0", ser_valid); end
      if (ser_out !== 2'b00) begin errors++; $display("FAIL rst_ser_out: got %b, expected 00", ser_out); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
      if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h, expected 00", rsp_data); end
      if (rsp_tmo !== 1'b0) begin errors++; $display("FAIL rst_rsp_tmo: got %b, expected 0", rsp_tmo); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Reset in the middle of a write frame.
      push_frame(1'b1, 6'h2D, 8'hA5);
      send_req(1'b1, 6'h2D, 8'hA5);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks += 2;
      if (ser_valid !== 1'b0) begin errors++; $display("FAIL midrst_ser_valid: got %b, expected 0", ser_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b, expected 1", req_ready); end
      beat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      b0 = beat_cnt;
      repeat (10) @(negedge clk);
      checks++;
      if (beat_cnt != b0) begin
         errors++;
         $display("FAIL midrst_no_beats: got %0d beats after release, expected 0", beat_cnt - b0);
      end
   endtask

   task automatic test_write();
      int hi;
      hi = 0;
      beat_q.push_back(2'b01);
      beat_q.push_back(2'b01); beat_q.push_back(2'b11); beat_q.push_back(2'b10);
      beat_q.push_back(2'b01); beat_q.push_back(2'b01); beat_q.push_back(2'b10); beat_q.push_back(2'b10);
      send_req(1'b1, 6'h2D, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         if (ser_valid === 1'b1 && req_ready === 1'b0) hi++;
         @(negedge clk);
      end
      checks += 4;
      if (hi != 8) begin errors++; $display("FAIL wr_frame_len: got %0d busy beat cycles, expected 8", hi); end
      if (ser_valid !== 1'b0) begin errors++; $display("FAIL wr_end_valid: got %b, expected 0", ser_valid); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_end_ready: got %b, expected 1", req_ready); end
      if (beat_q.size() != 0) begin errors++; $display("FAIL wr_beats_left: got %0d pending, expected 0", beat_q.size()); end
   endtask

   task automatic test_read();
      push_frame(1'b0, 6'h03, 8'h00);
      rsp_q.push_back({1'b0, 8'h36});
      send_req(1'b0, 6'h03, 8'h00);
      repeat (4) @(negedge clk);
      drive_reply(8'h36, 2);
      checks += 3;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b, expected 1", rsp_valid); end
      if (rsp_data !== 8'h36) begin errors++; $display("FAIL rd_rsp_data: got %h, expected 36", rsp_data); end
      if (rsp_tmo !== 1'b0) begin errors++; $display("FAIL rd_rsp_tmo: got %b, expected 0", rsp_tmo); end
      @(negedge clk);
      checks += 2;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b, expected 0", rsp_valid); end
      if (rsp_data !== 8'h36) begin errors++; $display("FAIL rd_hold: got %h, expected 36", rsp_data); end
   endtask

   task automatic test_timeout();
      int  n;
      logic found;
      n     = 0;
      found = 1'b0;
      push_frame(1'b0, 6'h15, 8'h00);
      rsp_q.push_back({1'b1, 8'h36});
      send_req(1'b0, 6'h15, 8'h00);
      for (int i = 0; i < TMO + 40; i++) begin
         if (rsp_valid) begin
            found = 1'b1;
            break;
         end
         n++;
         @(negedge clk);
      end
      checks += 5;
      if (!found) begin errors++; $display("FAIL tmo_seen: got no rsp in %0d cycles, expected one", TMO + 40); end
      if (n != 4 + TMO) begin errors++; $display("FAIL tmo_latency: got %0d cycles after CMD, expected %0d", n, 4 + TMO); end
      if (rsp_tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b, expected 1", rsp_tmo); end
      if (rsp_data !== 8'h36) begin errors++; $display("FAIL tmo_data: got %h, expected 36", rsp_data); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready_early: got %b, expected 0", req_ready); end
      @(negedge clk);
      checks += 2;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready_after: got %b, expected 1", req_ready); end
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b, expected 0", rsp_valid); end
   endtask

   task automatic test_stray();
      push_frame(1'b1, 6'h11, 8'h3C);
      fork
         send_req(1'b1, 6'h11, 8'h3C);
         begin
            for (int i = 0; i < 14; i++) begin
               ser_in_vld = i[0];
               ser_in     = 2'b10;
               @(negedge clk);
            end
            ser_in_vld = 1'b0;
            ser_in     = 2'b00;
         end
      join
      checks += 2;
      if (beat_q.size() != 0) begin errors++; $display("FAIL stray_beats_left: got %0d pending, expected 0", beat_q.size()); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL stray_idle: got req_ready=%b, expected 1", req_ready); end
      push_frame(1'b0, 6'h2A, 8'h00);
      rsp_q.push_back({1'b0, 8'hC9});
      send_req(1'b0, 6'h2A, 8'h00);
      repeat (4) @(negedge clk);
      drive_reply(8'hC9, 0);
      checks += 2;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stray_rsp_valid: got %b, expected 1", rsp_valid); end
      if (rsp_data !== 8'hC9) begin errors++; $display("FAIL stray_rsp_data: got %h, expected c9", rsp_data); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] vs;
      logic       rdy8;
      logic       ok;
      int         hi;
      vs   = '0;
      rdy8 = 1'b0;
      ok   = 1'b0;
      hi   = 0;
      push_frame(1'b1, 6'h3F, 8'h81);
      push_frame(1'b0, 6'h00, 8'h00);
      rsp_q.push_back({1'b0, 8'hFF});
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 6'h3F;
      req_wdata = 8'h81;
      for (int i = 0; i < 50; i++) begin
         if (req_ready) ok = 1'b1;
         @(negedge clk);
         if (ok) break;
      end
      req_write = 1'b0;
      req_addr  = 6'h00;
      req_wdata = 8'h00;
      for (int k = 0; k < 10; k++) begin
         vs[k] = ser_valid;
         if (k == 8) rdy8 = req_ready;
         if (k < 9) @(negedge clk);
      end
      req_valid = 1'b0;
      for (int k = 0; k < 8; k++) if (vs[k] === 1'b1) hi++;
      checks += 5;
      if (!ok) begin errors++; $display("FAIL b2b_accept: got no accept, expected req_ready"); end
      if (hi != 8) begin errors++; $display("FAIL b2b_write_len: got %0d beat cycles, expected 8", hi); end
      if (vs[8] !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ser_valid=%b, expected 0", vs[8]); end
      if (rdy8 !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready: got %b, expected 1", rdy8); end
      if (vs[9] !== 1'b1) begin errors++; $display("FAIL b2b_cmd2: got ser_valid=%b, expected 1", vs[9]); end
      repeat (4) @(negedge clk);
      drive_reply(8'hFF, 1);
      checks += 2;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid: got %b, expected 1", rsp_valid); end
      if (rsp_data !== 8'hFF) begin errors++; $display("FAIL b2b_rsp_data: got %h, expected ff", rsp_data); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_stray();
      test_back_to_back();
      repeat (5) @(negedge clk);
      checks += 2;
      if (beat_q.size() != 0) begin errors++; $display("FAIL end_beats: got %0d unsent beats, expected 0", beat_q.size()); end
      if (rsp_q.size() != 0) begin errors++; $display("FAIL end_rsps: got %0d missing responses, expected 0", rsp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
